// File: rtl/keypad_pkg.sv
// Shared types, key codes and the row/column keymap for the 4x4 keypad setpoint reader.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } deb_state_t;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = KEY_A;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = KEY_B;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'd0;
            4'hE:    code = KEY_HASH;
            4'hF:    code = KEY_D;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_frame_scanner.sv
// Column scanner: divider, one-low column drive, 2-flop row synchronizer and frame capture.
module keypad_frame_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] frame,
    output logic        frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div_r;
    logic [1:0]       col_idx_r;
    logic [3:0]       col_r;
    logic [3:0]       row_meta_r;
    logic [3:0]       row_sync_r;
    logic [15:0]      frame_r;
    logic             tick_s;
    logic [15:0]      frame_s;

    assign tick_s = (div_r == DIV_W'(SCAN_DIV - 1));

    // Frame bit c*4+r is set when key (r,c) reads pressed; the live slot is merged so the
    // debouncer sees the complete frame on the column-3 tick itself.
    always_comb begin
        frame_s = frame_r;
        frame_s[{col_idx_r, 2'b00} +: 4] = ~row_sync_r;
    end

    // Divider, column rotation, row synchronizer and per-column capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r      <= '0;
            col_idx_r  <= 2'd0;
            col_r      <= 4'b1110;
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
            frame_r    <= 16'd0;
        end else begin
            row_meta_r <= row;
            row_sync_r <= row_meta_r;
            if (tick_s) begin
                div_r     <= '0;
                col_idx_r <= col_idx_r + 2'd1;
                col_r     <= {col_r[2:0], col_r[3]};
                frame_r   <= frame_s;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

    assign col        = col_r;
    assign frame      = frame_s;
    assign frame_done = tick_s & (col_idx_r == 2'd3);

endmodule

// File: rtl/keypad_setpoint_reader.sv
// 4x4 keypad reader: frame debouncer with single-key decode and a 4-digit decimal setpoint entry.
module keypad_setpoint_reader
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [13:0] entry,
    output logic [2:0]  digit_cnt,
    output logic [13:0] setpoint,
    output logic        setpoint_valid
);

    localparam logic [7:0] DEB_N = 8'(DEBOUNCE_FRAMES);

    logic [15:0] frame_s;
    logic        frame_done_s;
    logic [4:0]  hits_s;
    logic [3:0]  hit_idx_s;
    logic [3:0]  hit_code_s;
    logic        is_none_s;
    logic        is_single_s;

    deb_state_t  state_r;
    logic [7:0]  cnt_r;
    logic [3:0]  cand_r;
    logic        key_valid_r;
    logic [3:0]  key_code_r;
    logic        key_held_r;
    logic [13:0] entry_r;
    logic [2:0]  digit_cnt_r;
    logic [13:0] setpoint_r;
    logic        setpoint_valid_r;

    keypad_frame_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
        .clk        (clk),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .frame      (frame_s),
        .frame_done (frame_done_s)
    );

    // Classify the frame by key count and locate the key when there is exactly one.
    always_comb begin
        hits_s    = 5'd0;
        hit_idx_s = 4'd0;
        for (int i = 0; i < 16; i++) begin
            hits_s    = hits_s + {4'd0, frame_s[i]};
            hit_idx_s = frame_s[i] ? 4'(i) : hit_idx_s;
        end
    end

    assign hit_code_s  = keymap(hit_idx_s[1:0], hit_idx_s[3:2]);
    assign is_none_s   = (hits_s == 5'd0);
    assign is_single_s = (hits_s == 5'd1);

    // Debounce FSM, advanced once per completed frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            cand_r      <= 4'd0;
            key_valid_r <= 1'b0;
            key_code_r  <= 4'd0;
            key_held_r  <= 1'b0;
        end else begin
            key_valid_r <= 1'b0;
            if (frame_done_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (is_single_s) begin
                            cand_r <= hit_code_s;
                            if (DEB_N <= 8'd1) begin
                                key_valid_r <= 1'b1;
                                key_code_r  <= hit_code_s;
                                key_held_r  <= 1'b1;
                                cnt_r       <= 8'd0;
                                state_r     <= ST_HELD;
                            end else begin
                                cnt_r   <= 8'd1;
                                state_r <= ST_CONFIRM;
                            end
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_CONFIRM: begin
                        if (is_single_s && (hit_code_s == cand_r)) begin
                            if ((cnt_r + 8'd1) >= DEB_N) begin
                                key_valid_r <= 1'b1;
                                key_code_r  <= cand_r;
                                key_held_r  <= 1'b1;
                                cnt_r       <= 8'd0;
                                state_r     <= ST_HELD;
                            end else begin
                                cnt_r <= cnt_r + 8'd1;
                            end
                        end else begin
                            cnt_r   <= 8'd0;
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        if (is_none_s) begin
                            if (DEB_N <= 8'd1) begin
                                key_held_r <= 1'b0;
                                cnt_r      <= 8'd0;
                                state_r    <= ST_IDLE;
                            end else begin
                                cnt_r   <= 8'd1;
                                state_r <= ST_RELEASE;
                            end
                        end else begin
                            state_r <= ST_HELD;
                        end
                    end
                    ST_RELEASE: begin
                        if (is_none_s) begin
                            if ((cnt_r + 8'd1) >= DEB_N) begin
                                key_held_r <= 1'b0;
                                cnt_r      <= 8'd0;
                                state_r    <= ST_IDLE;
                            end else begin
                                cnt_r <= cnt_r + 8'd1;
                            end
                        end else begin
                            cnt_r   <= 8'd0;
                            state_r <= ST_HELD;
                        end
                    end
                    default: begin
                        key_held_r <= 1'b0;
                        cnt_r      <= 8'd0;
                        state_r    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Setpoint entry: digits accumulate up to four, * clears, # commits a non-empty entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_r          <= 14'd0;
            digit_cnt_r      <= 3'd0;
            setpoint_r       <= 14'd0;
            setpoint_valid_r <= 1'b0;
        end else begin
            setpoint_valid_r <= 1'b0;
            if (key_valid_r) begin
                if (key_code_r <= 4'd9) begin
                    if (digit_cnt_r < 3'd4) begin
                        entry_r     <= entry_r * 14'd10 + {10'd0, key_code_r};
                        digit_cnt_r <= digit_cnt_r + 3'd1;
                    end
                end else if (key_code_r == KEY_STAR) begin
                    entry_r     <= 14'd0;
                    digit_cnt_r <= 3'd0;
                end else if ((key_code_r == KEY_HASH) && (digit_cnt_r != 3'd0)) begin
                    setpoint_r       <= entry_r;
                    setpoint_valid_r <= 1'b1;
                    entry_r          <= 14'd0;
                    digit_cnt_r      <= 3'd0;
                end
            end
        end
    end

    assign key_valid      = key_valid_r;
    assign key_code       = key_code_r;
    assign key_held       = key_held_r;
    assign entry          = entry_r;
    assign digit_cnt      = digit_cnt_r;
    assign setpoint       = setpoint_r;
    assign setpoint_valid = setpoint_valid_r;

endmodule

// File: tb/tb_keypad_setpoint_reader.sv
// Directed bench for keypad_setpoint_reader with a matrix keypad model (SCAN_DIV=4, DEBOUNCE_FRAMES=3).
module tb_keypad_setpoint_reader;

    localparam int SD    = 4;
    localparam int DF    = 3;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [15:0] pressed = 16'd0;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [13:0] entry;
    logic [2:0]  digit_cnt;
    logic [13:0] setpoint;
    logic        setpoint_valid;

    int checks = 0;
    int failures = 0;
    int kv_cnt = 0;
    int kv_code = -1;
    int sv_cnt = 0;
    int kv_base;
    int sv_base;

    keypad_setpoint_reader #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk            (clk),
        .reset          (reset),
        .row            (row),
        .col            (col),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_held       (key_held),
        .entry          (entry),
        .digit_cnt      (digit_cnt),
        .setpoint       (setpoint),
        .setpoint_valid (setpoint_valid)
    );

    always #5 clk = ~clk;

    // Keypad model: pressed bit r*4+c pulls row r low while column c is driven low.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(pressed[r*4 +: 4] & ~col);
        end
    end

    // Pulse monitor sampled on the inactive edge.
    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt  = kv_cnt + 1;
            kv_code = int'(key_code);
        end
        if (setpoint_valid) sv_cnt = sv_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input int code);
        case (code)
            1: return 0;   2: return 1;   3: return 2;   10: return 3;
            4: return 4;   5: return 5;   6: return 6;   11: return 7;
            7: return 8;   8: return 9;   9: return 10;  12: return 11;
            14: return 12; 0: return 13;  15: return 14; 13: return 15;
            default: return 0;
        endcase
    endfunction

    task automatic hold(input logic [15:0] mask, input int frames);
        pressed = mask;
        repeat (frames * FRAME) @(negedge clk);
    endtask

    task automatic press(input int code);
        logic [15:0] m;
        m = 16'd1 << idx_of(code);
        hold(m, 5);
        hold(16'd0, 6);
    endtask

    initial begin
        logic [3:0] col_seq [4];
        col_seq[0] = 4'b1101; col_seq[1] = 4'b1011; col_seq[2] = 4'b0111; col_seq[3] = 4'b1110;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_col", int'(col), 4'b1110);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_code", int'(key_code), 0);
        check("rst_key_held", int'(key_held), 0);
        check("rst_entry", int'(entry), 0);
        check("rst_digit_cnt", int'(digit_cnt), 0);
        check("rst_setpoint", int'(setpoint), 0);
        check("rst_setpoint_valid", int'(setpoint_valid), 0);
        for (int k = 0; k < 4; k++) begin
            repeat (SD) @(negedge clk);
            check("col_cycle", int'(col), int'(col_seq[k]));
        end

        // Long hold of 7: one press, held until release is confirmed.
        kv_base = kv_cnt;
        hold(16'd1 << idx_of(7), 6);
        check("hold7_kv_count", kv_cnt - kv_base, 1);
        check("hold7_code", kv_code, 7);
        check("hold7_key_held", int'(key_held), 1);
        hold(16'd0, 1);
        check("hold7_held_after_1_release_frame", int'(key_held), 1);
        hold(16'd0, 5);
        check("hold7_held_cleared", int'(key_held), 0);
        check("hold7_entry", int'(entry), 7);
        check("hold7_digit_cnt", int'(digit_cnt), 1);

        // Clear, then 1 2 3 4 5 #.
        press(14);
        check("star_entry", int'(entry), 0);
        check("star_digit_cnt", int'(digit_cnt), 0);
        kv_base = kv_cnt;
        sv_base = sv_cnt;
        press(1); press(2); press(3); press(4);
        check("seq_kv_count", kv_cnt - kv_base, 4);
        check("seq_entry_1234", int'(entry), 1234);
        check("seq_digit_cnt_4", int'(digit_cnt), 4);
        press(5);
        check("seq_fifth_ignored", int'(entry), 1234);
        check("seq_digit_cnt_still_4", int'(digit_cnt), 4);
        check("seq_no_commit_yet", sv_cnt - sv_base, 0);
        press(15);
        check("commit_setpoint", int'(setpoint), 1234);
        check("commit_pulse_cycles", sv_cnt - sv_base, 1);
        check("commit_entry_cleared", int'(entry), 0);
        check("commit_digit_cnt_cleared", int'(digit_cnt), 0);
        check("commit_last_code", kv_code, 15);

        // Bounce: 2 frames on, 1 off, 2 on never reaches 3 consecutive frames.
        kv_base = kv_cnt;
        hold(16'd1 << idx_of(3), 2);
        hold(16'd0, 1);
        hold(16'd1 << idx_of(3), 2);
        hold(16'd0, 6);
        check("bounce_no_key", kv_cnt - kv_base, 0);
        check("bounce_entry", int'(entry), 0);

        // Two keys together are rejected; the survivor is accepted once alone.
        kv_base = kv_cnt;
        hold((16'd1 << idx_of(1)) | (16'd1 << idx_of(5)), 5);
        check("multi_no_key", kv_cnt - kv_base, 0);
        check("multi_not_held", int'(key_held), 0);
        hold(16'd1 << idx_of(1), 5);
        check("multi_survivor_count", kv_cnt - kv_base, 1);
        check("multi_survivor_code", kv_code, 1);
        hold(16'd0, 6);
        check("multi_entry", int'(entry), 1);

        // * 4 2 * # : entry 42, cleared, and # on empty entry does not commit.
        sv_base = sv_cnt;
        press(14); press(4); press(2);
        check("e42_entry", int'(entry), 42);
        check("e42_digit_cnt", int'(digit_cnt), 2);
        press(14);
        check("e42_cleared", int'(entry), 0);
        press(15);
        check("empty_hash_no_pulse", sv_cnt - sv_base, 0);
        check("empty_hash_setpoint_kept", int'(setpoint), 1234);
        check("empty_hash_code", kv_code, 15);

        // Reset mid-entry drops entry and setpoint.
        press(9);
        check("pre_reset_entry", int'(entry), 9);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_entry", int'(entry), 0);
        check("reset_setpoint", int'(setpoint), 0);
        check("reset_digit_cnt", int'(digit_cnt), 0);
        check("reset_col", int'(col), 4'b1110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
